// File: rtl/tpu_preload_sequencer.sv
// Purpose : sequences one TPU pre-load job: streamed 64-word weight/activation load,
//           then compensation-weight preload, weight preload, calculation and a done pulse.
// Latency : start sampled in IDLE -> LOAD next cycle; with in_valid held high, done in cycle 99.
// Backpressure: in_ready is high only in LOAD. in_valid low stalls the load indefinitely.
//           The later phases run for fixed lengths and cannot be stalled.
// Ports   : clk/rst_n (async active-low); start_i (job request); in_valid_i/in_ready_o (load handshake);
//           mem_wr_en_o, weight_wr_addr_o, act_wr_addr_o (memory write side); load_mem_done_o (level);
//           preload_cweight_o, preload_weight_o, cal_o (phase strobes); row_idx_o, cal_cnt_o (phase
//           indices); busy_o, done_o (job status).
module tpu_preload_sequencer #(
   parameter int ARRAY_N    = 8,
   parameter int ADDR_W     = 6,
   parameter int CW_ROWS    = 3,
   parameter int CAL_CYCLES = 23
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic              mem_wr_en_o,
   output logic [ADDR_W-1:0] weight_wr_addr_o,
   output logic [ADDR_W-1:0] act_wr_addr_o,
   output logic              load_mem_done_o,
   output logic              preload_cweight_o,
   output logic              preload_weight_o,
   output logic              cal_o,
   output logic [2:0]        row_idx_o,
   output logic [4:0]        cal_cnt_o,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_PRE_CW = 3'd2,
      S_PRE_W  = 3'd3,
      S_CAL    = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(ARRAY_N * ARRAY_N - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
   localparam logic [2:0]        ROW_CW_LAST = 3'(CW_ROWS - 1);
   localparam logic [2:0]        ROW_W_LAST  = 3'(ARRAY_N - 1);
   localparam logic [4:0]        CAL_LAST    = 5'(CAL_CYCLES - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [2:0]        row_q,   row_d;
   logic [4:0]        cal_q,   cal_d;
   logic              lmd_q,   lmd_d;
   logic              accept;

   // The only input-to-output path: a beat is written in the same cycle it is offered.
   assign accept = in_valid_i & (state_q == S_LOAD);

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         row_q   <= '0;
         cal_q   <= '0;
         lmd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         row_q   <= row_d;
         cal_q   <= cal_d;
         lmd_q   <= lmd_d;
      end
   end

   // Next-state logic. Each phase counter returns to 0 when its phase ends,
   // so the index outputs are already 0 outside their phases.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      row_d   = row_q;
      cal_d   = cal_q;
      lmd_d   = lmd_q;
      case (state_q)
         S_IDLE: begin
            addr_d = '0;
            row_d  = '0;
            cal_d  = '0;
            if (start_i) begin
               state_d = S_LOAD;
               lmd_d   = 1'b0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               // Increments from the last address back to 0.
               addr_d = addr_q + ADDR_ONE;
               if (addr_q == ADDR_LAST) begin
                  state_d = S_PRE_CW;
                  lmd_d   = 1'b1;
               end
            end
         end
         S_PRE_CW: begin
            if (row_q == ROW_CW_LAST) begin
               row_d   = '0;
               state_d = S_PRE_W;
            end else begin
               row_d = row_q + 3'd1;
            end
         end
         S_PRE_W: begin
            if (row_q == ROW_W_LAST) begin
               row_d   = '0;
               state_d = S_CAL;
            end else begin
               row_d = row_q + 3'd1;
            end
         end
         S_CAL: begin
            if (cal_q == CAL_LAST) begin
               cal_d   = '0;
               state_d = S_DONE;
            end else begin
               cal_d = cal_q + 5'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from registered state; start is never seen by the outputs.
   always_comb begin
      in_ready_o        = (state_q == S_LOAD);
      mem_wr_en_o       = accept;
      weight_wr_addr_o  = addr_q;
      act_wr_addr_o     = addr_q;
      load_mem_done_o   = lmd_q;
      preload_cweight_o = (state_q == S_PRE_CW);
      preload_weight_o  = (state_q == S_PRE_W);
      cal_o             = (state_q == S_CAL);
      row_idx_o         = ((state_q == S_PRE_CW) || (state_q == S_PRE_W)) ? row_q : 3'd0;
      cal_cnt_o         = (state_q == S_CAL) ? cal_q : 5'd0;
      busy_o            = (state_q != S_IDLE);
      done_o            = (state_q == S_DONE);
   end

endmodule

// File: tb/tb_tpu_preload_sequencer.sv
// Bench for tpu_preload_sequencer. The expected trace is computed from the job timeline:
// the load lasts until 64 beats are accepted, and the fixed-length phases are then
// placed by their offset from the last accepted beat.
module tb_tpu_preload_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_i;
   logic       in_valid_i;
   logic       in_ready_o;
   logic       mem_wr_en_o;
   logic [5:0] weight_wr_addr_o;
   logic [5:0] act_wr_addr_o;
   logic       load_mem_done_o;
   logic       preload_cweight_o;
   logic       preload_weight_o;
   logic       cal_o;
   logic [2:0] row_idx_o;
   logic [4:0] cal_cnt_o;
   logic       busy_o;
   logic       done_o;

   int   n_checks = 0;
   int   n_errors = 0;
   logic lmd_exp;

   tpu_preload_sequencer dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start_i           (start_i),
      .in_valid_i        (in_valid_i),
      .in_ready_o        (in_ready_o),
      .mem_wr_en_o       (mem_wr_en_o),
      .weight_wr_addr_o  (weight_wr_addr_o),
      .act_wr_addr_o     (act_wr_addr_o),
      .load_mem_done_o   (load_mem_done_o),
      .preload_cweight_o (preload_cweight_o),
      .preload_weight_o  (preload_weight_o),
      .cal_o             (cal_o),
      .row_idx_o         (row_idx_o),
      .cal_cnt_o         (cal_cnt_o),
      .busy_o            (busy_o),
      .done_o            (done_o)
   );

   always #5 clk = ~clk;

   // Fields: ready, wr_en, waddr, aaddr, load_done, pre_cw, pre_w, cal, row, cal_cnt, busy, done
   function automatic logic [27:0] obs_vec();
      return {in_ready_o, mem_wr_en_o, weight_wr_addr_o, act_wr_addr_o, load_mem_done_o,
              preload_cweight_o, preload_weight_o, cal_o, row_idx_o, cal_cnt_o, busy_o, done_o};
   endfunction

   function automatic logic [27:0] exp_vec(input logic rdy, input logic wr, input logic [5:0] wa,
                                           input logic [5:0] aa, input logic lmd, input logic pcw,
                                           input logic pw, input logic cl, input logic [2:0] row,
                                           input logic [4:0] cc, input logic bsy, input logic dn);
      return {rdy, wr, wa, aa, lmd, pcw, pw, cl, row, cc, bsy, dn};
   endfunction

   task automatic check(input string tag, input int cyc, input logic [27:0] obs, input logic [27:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   // mode 0: in_valid held high; 1: valid on odd cycles only; 2: random valid.
   // strays: extra start pulses in cycles 10, 70 and 99. abort: reset when cal_cnt = 5.
   task automatic run_job(input int mode, input bit strays, input bit abort);
      int   beats;
      int   load_end;
      int   k;
      int   d;
      logic v;
      bit   fin;
      beats    = 0;
      load_end = -1;
      k        = 0;
      fin      = 1'b0;
      // Cycle 0: IDLE, start presented and sampled on the next edge.
      @(posedge clk); #1;
      start_i    = 1'b1;
      in_valid_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_before_start", k, obs_vec(), exp_vec(0, 0, 0, 0, lmd_exp, 0, 0, 0, 0, 0, 0, 0));
      lmd_exp = 1'b0;
      while (!fin) begin
         k++;
         @(posedge clk); #1;
         start_i = strays && (k == 10 || k == 70 || k == 99);
         case (mode)
            0:       v = 1'b1;
            1:       v = k[0];
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         in_valid_i = v;
         @(negedge clk);
         if (load_end < 0) begin
            check("load", k, obs_vec(), exp_vec(1, v, beats[5:0], beats[5:0], 0, 0, 0, 0, 0, 0, 1, 0));
            if (v) begin
               beats++;
               if (beats == 64) begin
                  load_end = k;
                  lmd_exp  = 1'b1;
               end
            end
            if (k > 2000) begin
               n_checks++;
               n_errors++;
               $error("FAIL load_timeout: beats=%0d required=64 within 2000 cycles", beats);
               fin = 1'b1;
            end
         end else begin
            d = k - load_end;
            if (d <= 3)
               check("pre_cw", k, obs_vec(), exp_vec(0, 0, 0, 0, 1, 1, 0, 0, 3'(d - 1), 0, 1, 0));
            else if (d <= 11)
               check("pre_w", k, obs_vec(), exp_vec(0, 0, 0, 0, 1, 0, 1, 0, 3'(d - 4), 0, 1, 0));
            else if (d <= 34)
               check("cal", k, obs_vec(), exp_vec(0, 0, 0, 0, 1, 0, 0, 1, 0, 5'(d - 12), 1, 0));
            else if (d == 35)
               check("done", k, obs_vec(), exp_vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1));
            else begin
               check("idle_after_job", k, obs_vec(), exp_vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
               if (d >= 37) fin = 1'b1;
            end
            if (abort && d == 17) begin
               // Assert reset mid-cycle, away from any clock edge.
               #2 rst_n = 1'b0;
               #1;
               lmd_exp = 1'b0;
               check("async_reset", k, obs_vec(), exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
               start_i = 1'b0;
               @(negedge clk);
               rst_n = 1'b1;
               @(negedge clk);
               check("idle_after_reset", k, obs_vec(), exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
               fin = 1'b1;
            end
         end
      end
      start_i = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      start_i    = 1'b0;
      in_valid_i = 1'b0;
      lmd_exp    = 1'b0;
      #1;
      check("reset_state", 0, obs_vec(), exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_job(0, 1'b0, 1'b0);   // reference timing, in_valid held high
      run_job(1, 1'b0, 1'b0);   // valid every other cycle
      run_job(0, 1'b1, 1'b0);   // stray starts during a job are ignored
      run_job(0, 1'b0, 1'b0);   // repeat job clears load_mem_done
      run_job(2, 1'b0, 1'b0);   // random valid, back-to-back jobs
      run_job(2, 1'b0, 1'b0);
      run_job(2, 1'b0, 1'b0);
      run_job(2, 1'b0, 1'b1);   // reset mid-calculation
      run_job(0, 1'b0, 1'b0);   // clean job after reset

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
